eeg_chip_dat_rx: RTL and testbench

- Chip-side receiver for the chip_dat stream (vld/rdy/lst/dat/cmd) that the testbench drives into the EEG chip.
- Classifies each packet as command or data from its first beat.
- Command beats become single-cycle config-write pulses.
- Data beats pass through a registered FIFO to the core datapath, with packet-last preserved, plus protocol-error and packet counters.

---
 rtl/eeg_chip_dat_rx_if.sv | 25 ++
 rtl/eeg_chip_dat_rx.sv | 110 +++++++++++
 tb/tb_eeg_chip_dat_rx.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eeg_chip_dat_rx_if.sv
// Stream bundle between the chip_dat source and the receiver, plus the
// receiver's core-side FIFO output.
interface eeg_chip_dat_rx_if #(
  parameter int DAT_DW = 32
);
  logic              chip_dat_vld;
  logic              chip_dat_rdy;
  logic              chip_dat_lst;
  logic              chip_dat_cmd;
  logic [DAT_DW-1:0] chip_dat_dat;
  logic              core_dat_vld;
  logic              core_dat_rdy;
  logic              core_dat_lst;
  logic [DAT_DW-1:0] core_dat_dat;

  modport master (
    output chip_dat_vld, chip_dat_lst, chip_dat_cmd, chip_dat_dat, core_dat_rdy,
    input  chip_dat_rdy, core_dat_vld, core_dat_lst, core_dat_dat
  );

  modport slave (
    input  chip_dat_vld, chip_dat_lst, chip_dat_cmd, chip_dat_dat, core_dat_rdy,
    output chip_dat_rdy, core_dat_vld, core_dat_lst, core_dat_dat
  );
endinterface

// File: rtl/eeg_chip_dat_rx.sv
// Chip-side chip_dat receiver: splits packets into config-write pulses
// (command) or a registered data FIFO (data), with error/packet counters.
module eeg_chip_dat_rx #(
  parameter int DAT_DW     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CFG_AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  eeg_chip_dat_rx_if.slave  bus,
  output logic              cfg_wr_vld,
  output logic [CFG_AW-1:0] cfg_wr_addr,
  output logic [15:0]       cfg_wr_dat,
  input  logic              err_clr,
  output logic              err_cmd_mismatch,
  output logic [15:0]       dat_pkt_cnt,
  output logic [15:0]       cmd_pkt_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CMD_PKT, DAT_PKT} state_t;

  state_t          state, state_nxt;
  logic            acc, beat_cmd, mismatch, push, pop;
  logic            fifo_full, fifo_empty;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [DAT_DW:0] mem [FIFO_DEPTH];

  // rdy comes only from registered occupancy, never from vld/cmd
  assign fifo_full        = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty       = (count == '0);
  assign bus.chip_dat_rdy = !fifo_full;
  assign acc              = bus.chip_dat_vld && !fifo_full;
  assign push             = acc && !beat_cmd;
  assign pop              = !fifo_empty && bus.core_dat_rdy;
  assign bus.core_dat_vld = !fifo_empty;
  assign {bus.core_dat_lst, bus.core_dat_dat} = fifo_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // First beat picks the packet type; later beats are forced to it
  always_comb begin
    state_nxt = state;
    beat_cmd  = 1'b0;
    mismatch  = 1'b0;
    case (state)
      IDLE: begin
        beat_cmd = bus.chip_dat_cmd;
        if (acc && !bus.chip_dat_lst) state_nxt = bus.chip_dat_cmd ? CMD_PKT : DAT_PKT;
      end
      CMD_PKT: begin
        beat_cmd = 1'b1;
        mismatch = acc && !bus.chip_dat_cmd;
        if (acc && bus.chip_dat_lst) state_nxt = IDLE;
      end
      DAT_PKT: begin
        mismatch = acc && bus.chip_dat_cmd;
        if (acc && bus.chip_dat_lst) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.chip_dat_lst, bus.chip_dat_dat};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_wr_vld       <= 1'b0;
      cfg_wr_addr      <= '0;
      cfg_wr_dat       <= '0;
      err_cmd_mismatch <= 1'b0;
      dat_pkt_cnt      <= '0;
      cmd_pkt_cnt      <= '0;
    end else begin
      cfg_wr_vld <= acc && beat_cmd;
      if (acc && beat_cmd) begin
        cfg_wr_addr <= bus.chip_dat_dat[16+CFG_AW-1:16];
        cfg_wr_dat  <= bus.chip_dat_dat[15:0];
      end
      if (mismatch)     err_cmd_mismatch <= 1'b1;
      else if (err_clr) err_cmd_mismatch <= 1'b0;
      if (acc && bus.chip_dat_lst) begin
        if (beat_cmd) cmd_pkt_cnt <= cmd_pkt_cnt + 16'd1;
        else          dat_pkt_cnt <= dat_pkt_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_eeg_chip_dat_rx.sv
// Randomized bench for eeg_chip_dat_rx: a packet-level model predicts cfg
// writes, FIFO output order, counters and the error flag.
module tb_eeg_chip_dat_rx;
  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0, rst = 1'b1, err_clr = 1'b0;
  logic          cfg_wr_vld, err_cmd_mismatch;
  logic [AW-1:0] cfg_wr_addr;
  logic [15:0]   cfg_wr_dat, dat_pkt_cnt, cmd_pkt_cnt;

  eeg_chip_dat_rx_if #(.DAT_DW(DW)) bus();

  eeg_chip_dat_rx #(.DAT_DW(DW), .FIFO_DEPTH(8), .CFG_AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cfg_wr_vld(cfg_wr_vld), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_dat(cfg_wr_dat),
    .err_clr(err_clr), .err_cmd_mismatch(err_cmd_mismatch),
    .dat_pkt_cnt(dat_pkt_cnt), .cmd_pkt_cnt(cmd_pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [AW-1:0] a; logic [15:0] d;} cfg_t;
  typedef struct {int cyc; logic lst; logic [DW-1:0] d;} core_t;

  cfg_t  exp_cfg[$], obs_cfg[$];
  core_t exp_core[$], obs_core[$];
  int    cyc = 0, acc_cnt = 0, tests = 0, fails = 0;
  bit    m_in_pkt, m_pkt_cmd, m_err, is_cmd, set_err;
  logic [15:0] m_dat_cnt, m_cmd_cnt;

  // Packet-level model: records what each accepted beat should produce
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_in_pkt = 0; m_err = 0; m_dat_cnt = 0; m_cmd_cnt = 0;
      exp_cfg.delete(); obs_cfg.delete(); exp_core.delete(); obs_core.delete();
    end else begin
      if (cfg_wr_vld) obs_cfg.push_back('{cyc, cfg_wr_addr, cfg_wr_dat});
      if (bus.core_dat_vld && bus.core_dat_rdy)
        obs_core.push_back('{cyc, bus.core_dat_lst, bus.core_dat_dat});
      set_err = 0;
      if (bus.chip_dat_vld && bus.chip_dat_rdy) begin
        acc_cnt++;
        if (!m_in_pkt) is_cmd = bus.chip_dat_cmd;
        else begin
          is_cmd = m_pkt_cmd;
          if (bus.chip_dat_cmd != m_pkt_cmd) set_err = 1;
        end
        if (is_cmd) exp_cfg.push_back('{cyc + 1, bus.chip_dat_dat[23:16], bus.chip_dat_dat[15:0]});
        else        exp_core.push_back('{cyc, bus.chip_dat_lst, bus.chip_dat_dat});
        if (bus.chip_dat_lst) begin
          m_in_pkt = 0;
          if (is_cmd) m_cmd_cnt = m_cmd_cnt + 16'd1;
          else        m_dat_cnt = m_dat_cnt + 16'd1;
        end else begin
          m_in_pkt = 1; m_pkt_cmd = is_cmd;
        end
      end
      if (set_err) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one beat and hold it until accepted (bounded wait)
  task automatic send_beat(input bit cmd, input bit lst, input logic [DW-1:0] d);
    int n = 0;
    bus.chip_dat_vld = 1'b1; bus.chip_dat_cmd = cmd; bus.chip_dat_lst = lst; bus.chip_dat_dat = d;
    forever begin
      @(posedge clk);
      if (bus.chip_dat_rdy) break;
      n++;
      if (n > 300) begin
        tests++; fails++;
        $display("FAIL send_timeout beat %0h never accepted, want accepted within 300 cycles", d);
        break;
      end
    end
    #1 bus.chip_dat_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(2);
    tests++; if (bus.chip_dat_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy got %b want 1", bus.chip_dat_rdy); end
    tests++; if (bus.core_dat_vld !== 1'b0) begin fails++; $display("FAIL reset_core_vld got %b want 0", bus.core_dat_vld); end
    tests++; if (bus.core_dat_dat !== '0 || bus.core_dat_lst !== 1'b0) begin fails++; $display("FAIL reset_core_dat got %0h/%b want 0/0", bus.core_dat_dat, bus.core_dat_lst); end
    tests++; if (cfg_wr_vld !== 1'b0 || cfg_wr_addr !== '0 || cfg_wr_dat !== '0) begin fails++; $display("FAIL reset_cfg got %b/%0h/%0h want 0/0/0", cfg_wr_vld, cfg_wr_addr, cfg_wr_dat); end
    tests++; if (err_cmd_mismatch !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err_cmd_mismatch); end
    tests++; if (dat_pkt_cnt !== 16'd0 || cmd_pkt_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0h/%0h want 0/0", dat_pkt_cnt, cmd_pkt_cnt); end
    rst = 1'b0; idle(1);
  endtask

  task automatic test_cmd_pkt();
    bus.core_dat_rdy = 1'b1;
    send_beat(1, 0, 32'h0012_ABCD);
    send_beat(1, 0, 32'h0034_1111);
    send_beat(1, 1, 32'h00FF_0000);
    // random command packets, random upper bits and gaps
    for (int p = 0; p < 6; p++) begin
      int len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        send_beat(1, b == len - 1, $urandom);
        if ($urandom_range(0, 2) == 0) idle(1);
      end
    end
    idle(3);
    tests++; if (obs_cfg.size() < 1 || obs_cfg[0].a !== 8'h12 || obs_cfg[0].d !== 16'hABCD) begin fails++; $display("FAIL cmd_first_write got size %0d want addr 12 dat abcd", obs_cfg.size()); end
    tests++; if (obs_cfg.size() != exp_cfg.size()) begin fails++; $display("FAIL cmd_cfg_count got %0d want %0d", obs_cfg.size(), exp_cfg.size()); end
    foreach (exp_cfg[i]) if (i < obs_cfg.size()) begin
      tests++;
      if (obs_cfg[i].cyc != exp_cfg[i].cyc || obs_cfg[i].a !== exp_cfg[i].a || obs_cfg[i].d !== exp_cfg[i].d) begin
        fails++; $display("FAIL cmd_cfg[%0d] got cyc %0d %0h/%0h want cyc %0d %0h/%0h", i, obs_cfg[i].cyc, obs_cfg[i].a, obs_cfg[i].d, exp_cfg[i].cyc, exp_cfg[i].a, exp_cfg[i].d);
      end
    end
    tests++; if (cmd_pkt_cnt !== m_cmd_cnt) begin fails++; $display("FAIL cmd_cnt got %0d want %0d", cmd_pkt_cnt, m_cmd_cnt); end
    tests++; if (obs_core.size() != 0 || bus.core_dat_vld !== 1'b0) begin fails++; $display("FAIL cmd_fifo_empty got %0d pops vld %b want 0/0", obs_core.size(), bus.core_dat_vld); end
    tests++; if (cfg_wr_addr !== obs_cfg[$].a) begin fails++; $display("FAIL cmd_addr_hold got %0h want %0h", cfg_wr_addr, obs_cfg[$].a); end
    exp_cfg.delete(); obs_cfg.delete();
  endtask

  task automatic test_data_pkt();
    bus.core_dat_rdy = 1'b1;
    for (int i = 1; i <= 5; i++) send_beat(0, i == 5, DW'(i));
    idle(3);
    tests++; if (obs_core.size() != 5) begin fails++; $display("FAIL data_count got %0d want 5", obs_core.size()); end
    foreach (exp_core[i]) if (i < obs_core.size()) begin
      tests++;
      if (obs_core[i].cyc != exp_core[i].cyc + 1 || obs_core[i].d !== exp_core[i].d || obs_core[i].lst !== exp_core[i].lst) begin
        fails++; $display("FAIL data_beat[%0d] got cyc %0d %0h/%b want cyc %0d %0h/%b", i, obs_core[i].cyc, obs_core[i].d, obs_core[i].lst, exp_core[i].cyc + 1, exp_core[i].d, exp_core[i].lst);
      end
    end
    tests++; if (dat_pkt_cnt !== m_dat_cnt) begin fails++; $display("FAIL data_cnt got %0d want %0d", dat_pkt_cnt, m_dat_cnt); end
    exp_core.delete(); obs_core.delete();
  endtask

  task automatic test_full();
    int acc0 = acc_cnt;
    bus.core_dat_rdy = 1'b0;
    fork
      for (int i = 0; i < 10; i++) send_beat(0, i == 9, 32'h100 + DW'(i));
      begin
        idle(14);
        tests++; if (acc_cnt - acc0 != 8) begin fails++; $display("FAIL full_accepted got %0d want 8", acc_cnt - acc0); end
        tests++; if (bus.chip_dat_rdy !== 1'b0) begin fails++; $display("FAIL full_rdy got %b want 0", bus.chip_dat_rdy); end
        bus.core_dat_rdy = 1'b1;
        #3;
        tests++; if (bus.chip_dat_rdy !== 1'b0) begin fails++; $display("FAIL full_rdy_same_cycle got %b want 0", bus.chip_dat_rdy); end
        idle(1);
        tests++; if (bus.chip_dat_rdy !== 1'b1) begin fails++; $display("FAIL full_rdy_after_pop got %b want 1", bus.chip_dat_rdy); end
      end
    join
    idle(12);
    tests++; if (obs_core.size() != 10 || exp_core.size() != 10) begin fails++; $display("FAIL full_count got %0d want 10", obs_core.size()); end
    foreach (exp_core[i]) if (i < obs_core.size()) begin
      tests++;
      if (obs_core[i].cyc <= exp_core[i].cyc || obs_core[i].d !== exp_core[i].d || obs_core[i].lst !== exp_core[i].lst) begin
        fails++; $display("FAIL full_beat[%0d] got %0h/%b want %0h/%b", i, obs_core[i].d, obs_core[i].lst, exp_core[i].d, exp_core[i].lst);
      end
    end
    tests++; if (dat_pkt_cnt !== m_dat_cnt) begin fails++; $display("FAIL full_cnt got %0d want %0d", dat_pkt_cnt, m_dat_cnt); end
    exp_core.delete(); obs_core.delete();
  endtask

  task automatic test_mismatch();
    bus.core_dat_rdy = 1'b1;
    send_beat(0, 0, 32'hA1);
    send_beat(1, 0, 32'h0077_00A2);
    send_beat(0, 1, 32'hA3);
    idle(3);
    tests++; if (err_cmd_mismatch !== 1'b1) begin fails++; $display("FAIL mis_err_set got %b want 1", err_cmd_mismatch); end
    tests++; if (obs_core.size() != 3 || obs_core[1].d !== 32'h0077_00A2) begin fails++; $display("FAIL mis_beat2 got %0d beats want 3 with beat2 770 0a2", obs_core.size()); end
    tests++; if (obs_cfg.size() != 0) begin fails++; $display("FAIL mis_no_cfg got %0d writes want 0", obs_cfg.size()); end
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    tests++; if (err_cmd_mismatch !== 1'b0) begin fails++; $display("FAIL mis_err_clr got %b want 0", err_cmd_mismatch); end
    // set and clear in the same cycle: set must win
    err_clr = 1'b1;
    send_beat(0, 0, 32'hB1);
    send_beat(1, 1, 32'hB2);
    tests++; if (err_cmd_mismatch !== m_err || m_err !== 1'b1) begin fails++; $display("FAIL mis_set_wins got %b want 1", err_cmd_mismatch); end
    idle(1); err_clr = 1'b0;
    tests++; if (err_cmd_mismatch !== 1'b0) begin fails++; $display("FAIL mis_err_clr2 got %b want 0", err_cmd_mismatch); end
    idle(3);
    exp_core.delete(); obs_core.delete(); exp_cfg.delete(); obs_cfg.delete();
  endtask

  task automatic test_random();
    bit done = 0;
    fork
      begin
        for (int p = 0; p < 25; p++) begin
          int len = $urandom_range(1, 5);
          bit c = 1'($urandom_range(0, 1));
          for (int b = 0; b < len; b++) begin
            bit bc = (b > 0 && $urandom_range(0, 7) == 0) ? !c : c;
            send_beat(bc, b == len - 1, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
          end
        end
        done = 1;
      end
      begin
        for (int k = 0; k < 3000 && !done; k++) begin
          @(posedge clk); #1 bus.core_dat_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.core_dat_rdy = 1'b1;
    idle(12);
    tests++; if (obs_core.size() != exp_core.size()) begin fails++; $display("FAIL rnd_core_count got %0d want %0d", obs_core.size(), exp_core.size()); end
    foreach (exp_core[i]) if (i < obs_core.size()) begin
      tests++;
      if (obs_core[i].cyc <= exp_core[i].cyc || obs_core[i].d !== exp_core[i].d || obs_core[i].lst !== exp_core[i].lst) begin
        fails++; $display("FAIL rnd_core[%0d] got %0h/%b want %0h/%b", i, obs_core[i].d, obs_core[i].lst, exp_core[i].d, exp_core[i].lst);
      end
    end
    tests++; if (obs_cfg.size() != exp_cfg.size()) begin fails++; $display("FAIL rnd_cfg_count got %0d want %0d", obs_cfg.size(), exp_cfg.size()); end
    foreach (exp_cfg[i]) if (i < obs_cfg.size()) begin
      tests++;
      if (obs_cfg[i].cyc != exp_cfg[i].cyc || obs_cfg[i].a !== exp_cfg[i].a || obs_cfg[i].d !== exp_cfg[i].d) begin
        fails++; $display("FAIL rnd_cfg[%0d] got %0h/%0h want %0h/%0h", i, obs_cfg[i].a, obs_cfg[i].d, exp_cfg[i].a, exp_cfg[i].d);
      end
    end
    tests++; if (dat_pkt_cnt !== m_dat_cnt || cmd_pkt_cnt !== m_cmd_cnt) begin fails++; $display("FAIL rnd_cnt got %0d/%0d want %0d/%0d", dat_pkt_cnt, cmd_pkt_cnt, m_dat_cnt, m_cmd_cnt); end
    tests++; if (err_cmd_mismatch !== m_err) begin fails++; $display("FAIL rnd_err got %b want %b", err_cmd_mismatch, m_err); end
    exp_core.delete(); obs_core.delete(); exp_cfg.delete(); obs_cfg.delete();
  endtask

  task automatic test_reset_mid();
    bus.core_dat_rdy = 1'b0;
    send_beat(0, 0, 32'hC1);
    send_beat(0, 0, 32'hC2);
    rst = 1'b1; idle(1); rst = 1'b0;
    tests++; if (bus.core_dat_vld !== 1'b0 || bus.chip_dat_rdy !== 1'b1) begin fails++; $display("FAIL rstmid_fifo got vld %b rdy %b want 0/1", bus.core_dat_vld, bus.chip_dat_rdy); end
    tests++; if (dat_pkt_cnt !== 16'd0 || cmd_pkt_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_cnt got %0d/%0d want 0/0", dat_pkt_cnt, cmd_pkt_cnt); end
    send_beat(1, 1, 32'h0056_BEEF);
    idle(2);
    tests++; if (obs_cfg.size() != 1 || exp_cfg.size() != 1) begin fails++; $display("FAIL rstmid_cfg_count got %0d want 1", obs_cfg.size()); end
    else begin
      tests++; if (obs_cfg[0].a !== 8'h56 || obs_cfg[0].d !== 16'hBEEF || obs_cfg[0].cyc != exp_cfg[0].cyc) begin fails++; $display("FAIL rstmid_cfg got %0h/%0h want 56/beef", obs_cfg[0].a, obs_cfg[0].d); end
    end
    tests++; if (cmd_pkt_cnt !== 16'd1) begin fails++; $display("FAIL rstmid_cmd_cnt got %0d want 1", cmd_pkt_cnt); end
    tests++; if (obs_core.size() != 0) begin fails++; $display("FAIL rstmid_no_core got %0d want 0", obs_core.size()); end
    exp_cfg.delete(); obs_cfg.delete();
  endtask

  task automatic test_wrap();
    int n = 0;
    rst = 1'b1; idle(1); rst = 1'b0;
    bus.core_dat_rdy = 1'b1;
    bus.chip_dat_vld = 1'b1; bus.chip_dat_lst = 1'b1; bus.chip_dat_cmd = 1'b0; bus.chip_dat_dat = $urandom;
    for (int g = 0; g < 70000 && n < 65535; g++) begin
      @(posedge clk);
      if (bus.chip_dat_rdy) n++;
      #1 bus.chip_dat_dat = $urandom;
    end
    bus.chip_dat_vld = 1'b0;
    tests++; if (dat_pkt_cnt !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload got %0h want ffff", dat_pkt_cnt); end
    send_beat(0, 1, 32'hDEAD_0001);
    tests++; if (dat_pkt_cnt !== 16'h0000) begin fails++; $display("FAIL wrap_cnt got %0h want 0", dat_pkt_cnt); end
    idle(3);
    tests++; if (obs_core.size() != 65536 || exp_core.size() != 65536) begin fails++; $display("FAIL wrap_core_count got %0d want 65536", obs_core.size()); end
    tests++; if (obs_core.size() > 0 && obs_core[$].d !== 32'hDEAD_0001) begin fails++; $display("FAIL wrap_last_beat got %0h want dead0001", obs_core[$].d); end
    exp_core.delete(); obs_core.delete();
  endtask

  initial begin
    bus.chip_dat_vld = 1'b0; bus.chip_dat_lst = 1'b0; bus.chip_dat_cmd = 1'b0;
    bus.chip_dat_dat = '0;   bus.core_dat_rdy = 1'b0;
    test_reset();
    test_cmd_pkt();
    test_data_pkt();
    test_full();
    test_mismatch();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
